instr_fetch_decode: RTL and testbench
=====================================

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of REQ-state cycles allowed without mem_ack (range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 fetch_req  in  1  SHALL be the controller's request to fetch the instruction at pc.
REQ-005 pc  in  32  SHALL be the fetch address, sampled only when a request is accepted.
REQ-006 mem_rd  out  1  SHALL be the memory read strobe.
REQ-007 mem_addr  out  32  SHALL be the latched fetch address.
REQ-008 mem_rdata  in  32  SHALL be the instruction word, qualified by mem_ack.
REQ-009 mem_ack  in  1  SHALL indicate that mem_rdata is valid this cycle.
REQ-010 instr_valid  out  1  SHALL indicate that all decoded field outputs hold a fetched instruction.
REQ-011 opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6, imm16 16 and target 26 (all out) SHALL be the MIPS fields [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0] and [25:0].
REQ-012 extSel  out  1  SHALL drive the sign-extend stage's select input: 1 selects zero-extension, 0 selects sign-extension.
REQ-013 busy  out  1  SHALL be high while in state REQ.
REQ-014 fetch_err  out  1  SHALL be a one-cycle pulse that flags a memory timeout.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and HOLD.
REQ-016 In IDLE, fetch_req=1 SHALL latch pc into mem_addr and move to REQ; mem_rd SHALL be high in the next cycle.
REQ-017 In REQ, mem_rd SHALL be 1 and a cycle counter SHALL increment each cycle, starting from 0 on entry.
REQ-018 In REQ, mem_ack=1 SHALL latch mem_rdata into the instruction register and move to HOLD; instr_valid and the fields SHALL be valid in the following cycle.
REQ-019 An ack in the first REQ cycle SHALL be accepted, giving a minimum of fetch_req cycle N -> instr_valid at N+2.
REQ-020 In REQ, if the counter reaches TIMEOUT_CYCLES-1 with no ack, the FSM SHALL go to IDLE and fetch_err SHALL be 1 for exactly the next cycle.
REQ-021 When ack and the timeout coincide in the same cycle, ack SHALL win: the instruction is latched and no error is raised.
REQ-022 In HOLD, instr_valid SHALL be 1 and the fields SHALL stay stable until the next accepted fetch_req.
REQ-023 In HOLD, fetch_req=1 SHALL latch pc and move to REQ; instr_valid SHALL go to 0 in the next cycle and the fields SHALL keep their old values.
REQ-024 fetch_req in REQ SHALL be ignored, and mem_ack in IDLE or HOLD SHALL be ignored.
REQ-025 extSel SHALL be registered together with the instruction: 1 for opcodes 0x0C (ANDI), 0x0D (ORI) and 0x0E (XORI), 0 otherwise.
REQ-026 The fields SHALL be pure bit-slices of the instruction register, with no arithmetic; any overlap between target and the other fields is intentional.
REQ-027 The counter SHALL be 8 bits wide and SHALL saturate, never wrapping.

Reset
REQ-028 On reset=1, the next state SHALL be IDLE regardless of the current state, including mid-REQ.
REQ-029 After reset: mem_rd, busy, fetch_err, instr_valid and extSel SHALL be 0; mem_addr, the instruction register (all fields) and the counter SHALL be 0.
REQ-030 reset SHALL take priority over fetch_req and mem_ack in the same cycle.

Structure
REQ-031 The shared package cpu_defs SHALL hold the opcode constants (OP_ANDI, OP_ORI, OP_XORI, OP_RTYPE) and the FSM state encoding.
REQ-032 Field slicing and extSel generation SHALL live in one combinational sub-module, instr_field_decode, instantiated on the register input.

Verification
REQ-033 fetch_req pc=0x00400000 in cycle 0, mem_ack with 0x2008FFF8 in cycle 2 -> cycle 3: instr_valid=1, opcode=0x08, rt=8, imm16=0xFFF8, extSel=0.
REQ-034 Same flow with 0x3408FFF8 -> opcode=0x0D, rs=0, rt=8, imm16=0xFFF8, extSel=1.
REQ-035 R-type 0x00221820 -> rs=1, rt=2, rd=3, shamt=0, funct=0x20, extSel=0; the fields hold while fetch_req=0 for 10 cycles.
REQ-036 No mem_ack for 16 REQ cycles -> one-cycle fetch_err pulse, state IDLE, instr_valid=0; ack arriving exactly in the 16th cycle -> HOLD and no fetch_err.
REQ-037 reset=1 in the 2nd REQ cycle -> next cycle: mem_rd=0, busy=0 and all outputs 0; a mem_ack one cycle later is ignored.
REQ-038 In HOLD, fetch_req pc=0x00400004 -> next cycle: mem_rd=1, mem_addr=0x00400004, instr_valid=0 and the old fields still held.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: MIPS opcode constants and the fetch FSM state encoding.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational MIPS field slicer plus the extension-select decision for the immediate path.
module instr_field_decode
  import cpu_defs::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic        ext_sel
);

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign target = instr[25:0];

  // Logical immediates are zero-extended; everything else takes the sign-extend path.
  assign ext_sel = (instr[31:26] == OP_ANDI) ||
                   (instr[31:26] == OP_ORI)  ||
                   (instr[31:26] == OP_XORI);

endmodule

// File: rtl/instr_fetch_decode.sv
// Single-outstanding instruction fetch with ack timeout, registering decoded MIPS fields.
module instr_fetch_decode
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic        extSel,
  output logic        busy,
  output logic        fetch_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t state_p0, state_nxt;
  logic [7:0]   cnt_p0;
  logic         latch_pc, latch_instr, timeout;

  logic [5:0]  d_opcode, d_funct;
  logic [4:0]  d_rs, d_rt, d_rd, d_shamt;
  logic [15:0] d_imm16;
  logic [25:0] d_target;
  logic        d_ext_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  instr_field_decode u_decode (
    .instr   (mem_rdata),
    .opcode  (d_opcode),
    .rs      (d_rs),
    .rt      (d_rt),
    .rd      (d_rd),
    .shamt   (d_shamt),
    .funct   (d_funct),
    .imm16   (d_imm16),
    .target  (d_target),
    .ext_sel (d_ext_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_p0;
    latch_pc    = 1'b0;
    latch_instr = 1'b0;
    timeout     = 1'b0;
    if (!reset) begin
      unique case (state_p0)
        ST_IDLE, ST_HOLD: begin
          if (fetch_req) begin
            latch_pc  = 1'b1;
            state_nxt = ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack in the timeout cycle still wins.
          if (mem_ack) begin
            latch_instr = 1'b1;
            state_nxt   = ST_HOLD;
          end else if (cnt_p0 >= CNT_LAST) begin
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign mem_rd      = (state_p0 == ST_REQ);
  assign busy        = (state_p0 == ST_REQ);
  assign instr_valid = (state_p0 == ST_HOLD);

  // ---- stage p0: address, counter and instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      cnt_p0    <= '0;
      fetch_err <= 1'b0;
      opcode    <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      shamt     <= '0;
      funct     <= '0;
      imm16     <= '0;
      target    <= '0;
      extSel    <= 1'b0;
    end else begin
      fetch_err <= timeout;
      if (latch_pc) begin
        mem_addr <= pc;
        cnt_p0   <= '0;
      end else if (state_p0 == ST_REQ) begin
        cnt_p0 <= sat_inc(cnt_p0);
      end
      if (latch_instr) begin
        opcode <= d_opcode;
        rs     <= d_rs;
        rt     <= d_rt;
        rd     <= d_rd;
        shamt  <= d_shamt;
        funct  <= d_funct;
        imm16  <= d_imm16;
        target <= d_target;
        extSel <= d_ext_sel;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: fetch flows, field decode, timeout and reset.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        instr_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic        extSel, busy, fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_decode #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .target      (target),
    .extSel      (extSel),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch; returns in the first REQ cycle.
  task automatic start_fetch(input logic [31:0] addr);
    fetch_req = 1'b1;
    pc        = addr;
    cyc();
    fetch_req = 1'b0;
    pc        = 32'hFFFF_FFFF;
  endtask

  // Ack after 'wait_cycles' REQ cycles; returns in the first HOLD cycle.
  task automatic ack_after(input int wait_cycles, input logic [31:0] word);
    for (int i = 0; i < wait_cycles; i++) cyc();
    mem_ack   = 1'b1;
    mem_rdata = word;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  logic [31:0] ext_words [4] = '{32'h3000_1234, 32'h3800_8001, 32'h3C01_8000, 32'h2C00_0001};
  logic        ext_exp   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; fetch_req = 1'b0; pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", fetch_err, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_ext", extSel, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_target", target, 0);
    check("rst_opcode", opcode, 0);

    // ADDI: ack in second REQ cycle, fetch_req during REQ ignored
    start_fetch(32'h0040_0000);
    check("f1_mem_rd", mem_rd, 1);
    check("f1_busy", busy, 1);
    check("f1_addr", mem_addr, 32'h0040_0000);
    fetch_req = 1'b1; pc = 32'hDEAD_0000;
    cyc();
    fetch_req = 1'b0;
    check("f1_req_ignored", mem_addr, 32'h0040_0000);
    check("f1_still_busy", busy, 1);
    ack_after(0, 32'h2008_FFF8);
    check("addi_valid", instr_valid, 1);
    check("addi_opcode", opcode, 6'h08);
    check("addi_rt", rt, 8);
    check("addi_imm", imm16, 16'hFFF8);
    check("addi_ext", extSel, 0);
    check("addi_busy", busy, 0);
    check("addi_mem_rd", mem_rd, 0);

    // Refetch from HOLD: old fields held while in REQ; ack in first REQ cycle
    start_fetch(32'h0040_0004);
    check("re_mem_rd", mem_rd, 1);
    check("re_addr", mem_addr, 32'h0040_0004);
    check("re_valid", instr_valid, 0);
    check("re_old_opcode", opcode, 6'h08);
    check("re_old_imm", imm16, 16'hFFF8);
    ack_after(0, 32'h3408_FFF8);
    check("ori_valid", instr_valid, 1);
    check("ori_opcode", opcode, 6'h0D);
    check("ori_rs", rs, 0);
    check("ori_rt", rt, 8);
    check("ori_imm", imm16, 16'hFFF8);
    check("ori_ext", extSel, 1);

    // R-type, then hold for 10 idle cycles with a stray ack
    start_fetch(32'h0040_0008);
    ack_after(1, 32'h0022_1820);
    for (int i = 0; i < 10; i++) begin
      mem_ack = (i == 3); mem_rdata = 32'hFFFF_FFFF;
      check("r_valid", instr_valid, 1);
      check("r_rs", rs, 1);
      check("r_rt", rt, 2);
      check("r_rd", rd, 3);
      check("r_shamt", shamt, 0);
      check("r_funct", funct, 6'h20);
      check("r_target", target, 26'h022_1820);
      check("r_ext", extSel, 0);
      cyc();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // extSel for ANDI, XORI and neighbouring non-logical opcodes
    for (int k = 0; k < 4; k++) begin
      start_fetch(32'h0000_0100 + 32'(k));
      ack_after(0, ext_words[k]);
      check("ext_sel", extSel, ext_exp[k]);
      check("ext_opcode", opcode, ext_words[k] >> 26);
      check("ext_imm", imm16, ext_words[k] & 32'hFFFF);
    end

    // Timeout: 16 REQ cycles without ack
    start_fetch(32'h0000_2000);
    for (int i = 0; i < 15; i++) cyc();
    check("to_busy_c16", busy, 1);
    check("to_err_c16", fetch_err, 0);
    cyc();
    check("to_err", fetch_err, 1);
    check("to_busy", busy, 0);
    check("to_mem_rd", mem_rd, 0);
    check("to_valid", instr_valid, 0);
    cyc();
    check("to_err_pulse", fetch_err, 0);
    check("to_idle", busy, 0);

    // Ack in the 16th REQ cycle wins over the timeout
    start_fetch(32'h0000_3000);
    ack_after(15, 32'h3108_00FF);
    check("late_valid", instr_valid, 1);
    check("late_err", fetch_err, 0);
    check("late_opcode", opcode, 6'h0C);
    check("late_ext", extSel, 1);
    cyc();
    check("late_err2", fetch_err, 0);
    check("late_hold", instr_valid, 1);

    // Reset in the second REQ cycle, then a stray ack in IDLE
    start_fetch(32'h0000_4000);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mr_mem_rd", mem_rd, 0);
    check("mr_busy", busy, 0);
    check("mr_valid", instr_valid, 0);
    check("mr_ext", extSel, 0);
    check("mr_addr", mem_addr, 0);
    check("mr_opcode", opcode, 0);
    check("mr_target", target, 0);
    check("mr_err", fetch_err, 0);
    mem_ack = 1'b1; mem_rdata = 32'h3408_1111;
    cyc();
    mem_ack = 1'b0;
    check("mr_ack_valid", instr_valid, 0);
    check("mr_ack_opcode", opcode, 0);
    check("mr_ack_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
